// File: rtl/fu_alu_pipe.sv
// ============================================================================
// fu_alu_pipe
// ----------------------------------------------------------------------------
// Pipelined integer ALU functional unit. Ops enter from the issue stage with
// a destination tag, flow through LAT elastic stages, and are presented to the
// write-back arbiter in issue order. A full output stage back-pressures the
// upstream stages, and flush kills everything in flight.
//
// Parameters
//   XLEN   operand/result width (power of two, >= 8)
//   LAT    issue-to-finish latency in cycles (1..4)
//   TAG_W  destination tag width
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   EN          issue valid (accepted when EN & ready)
//   ready       unit can accept an op this cycle (combinational)
//   ALUControl  opcode
//   ALUA, ALUB  operands
//   tag_in      destination tag of the issued op
//   finish      result valid at the output stage
//   ack         write-back takes the result this cycle
//   res         result (0 when finish=0)
//   zero        res == 0 (0 when finish=0)
//   overflow    signed overflow for ADD/SUB (0 when finish=0)
//   tag_out     tag of the presented result (0 when finish=0)
//   flush       synchronous kill of all in-flight ops
// ============================================================================
module fu_alu_pipe #(
    parameter int XLEN  = 32,
    parameter int LAT   = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    output logic             ready,
    input  logic [3:0]       ALUControl,
    input  logic [XLEN-1:0]  ALUA,
    input  logic [XLEN-1:0]  ALUB,
    input  logic [TAG_W-1:0] tag_in,
    output logic             finish,
    input  logic             ack,
    output logic [XLEN-1:0]  res,
    output logic             zero,
    output logic             overflow,
    output logic [TAG_W-1:0] tag_out,
    input  logic             flush
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_AP4  = 4'b1011;
    localparam logic [3:0] OP_BOUT = 4'b1100;

    // Stage 1: raw operands, opcode and tag
    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [XLEN-1:0]  s1_a;
    logic [XLEN-1:0]  s1_b;
    logic [TAG_W-1:0] s1_tag;

    // Per-stage valid bits and "slot will be free after this edge" flags
    logic [LAT:1]     valid_vec;
    logic [LAT:1]     free;
    logic             accept;

    // ALU datapath
    logic [XLEN-1:0]  sum;
    logic [XLEN:0]    diff_ext;
    logic [XLEN-1:0]  diff;
    logic             borrow;
    logic             add_ovf;
    logic             sub_ovf;
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  alu_res;
    logic             alu_ovf;

    // Output-stage payload before finish gating
    logic [XLEN-1:0]  out_res;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    assign sum      = s1_a + s1_b;
    assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};
    assign diff     = diff_ext[XLEN-1:0];
    assign borrow   = diff_ext[XLEN];
    assign shamt    = s1_b[SHW-1:0];

    assign add_ovf  = (s1_a[XLEN-1] == s1_b[XLEN-1]) && (sum[XLEN-1] != s1_a[XLEN-1]);
    assign sub_ovf  = (s1_a[XLEN-1] != s1_b[XLEN-1]) && (diff[XLEN-1] != s1_a[XLEN-1]);

    // Combinational ALU on the stage-1 registers. Unknown opcodes fall to the
    // default and still retire normally with a zero result.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_SLL:  alu_res = s1_a << shamt;
            OP_SRL:  alu_res = s1_a >> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, diff[XLEN-1] ^ sub_ovf};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, borrow};
            OP_SRA:  alu_res = $unsigned($signed(s1_a) >>> shamt);
            OP_AP4:  alu_res = s1_a + XLEN'(4);
            OP_BOUT: alu_res = s1_b;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Free-slot chain from the output stage back to stage 1: a stage can take
    // new contents if it is empty or its current contents move on this edge.
    always_comb begin
        logic f;
        f         = ~valid_vec[LAT] | ack;
        free      = '0;
        free[LAT] = f;
        for (int i = LAT - 1; i >= 1; i--) begin
            f       = ~valid_vec[i] | f;
            free[i] = f;
        end
    end

    // Flush blocks acceptance in its own cycle, so ready drops with it.
    assign ready        = free[1] & ~flush;
    assign accept       = EN & ready;
    assign valid_vec[1] = s1_valid;

    // Stage 1 register: loads a new op (or a bubble) whenever its slot frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (free[1]) begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= ALUControl;
                s1_a   <= ALUA;
                s1_b   <= ALUB;
                s1_tag <= tag_in;
            end
        end
    end

    generate
        if (LAT == 1) begin : g_single
            // Stage 1 is also the output stage; the result stays combinational.
            assign out_res = alu_res;
            assign out_ovf = alu_ovf;
            assign out_tag = s1_tag;
        end else begin : g_multi
            logic [LAT:2]     p_valid;
            logic [XLEN-1:0]  p_res [2:LAT];
            logic [LAT:2]     p_ovf;
            logic [TAG_W-1:0] p_tag [2:LAT];

            assign valid_vec[LAT:2] = p_valid;

            // Result stages: stage 2 captures the ALU output, later stages
            // shift the finished result forward when their slot frees.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_valid <= '0;
                    p_ovf   <= '0;
                    for (int i = 2; i <= LAT; i++) begin
                        p_res[i] <= '0;
                        p_tag[i] <= '0;
                    end
                end else if (flush) begin
                    p_valid <= '0;
                end else begin
                    if (free[2]) begin
                        p_valid[2] <= s1_valid;
                        if (s1_valid) begin
                            p_res[2] <= alu_res;
                            p_ovf[2] <= alu_ovf;
                            p_tag[2] <= s1_tag;
                        end
                    end
                    for (int i = 3; i <= LAT; i++) begin
                        if (free[i]) begin
                            p_valid[i] <= p_valid[i-1];
                            if (p_valid[i-1]) begin
                                p_res[i] <= p_res[i-1];
                                p_ovf[i] <= p_ovf[i-1];
                                p_tag[i] <= p_tag[i-1];
                            end
                        end
                    end
                end
            end

            assign out_res = p_res[LAT];
            assign out_ovf = p_ovf[LAT];
            assign out_tag = p_tag[LAT];
        end
    endgenerate

    // Outputs read as zero whenever nothing valid is presented.
    assign finish   = valid_vec[LAT];
    assign res      = finish ? out_res : '0;
    assign zero     = finish & (out_res == '0);
    assign overflow = finish & out_ovf;
    assign tag_out  = finish ? out_tag : '0;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// ============================================================================
// tb_fu_alu_pipe
// ----------------------------------------------------------------------------
// Directed testbench for fu_alu_pipe. Three instances cover the default
// configuration (LAT=2, XLEN=32), a deeper pipe (LAT=3) for back-pressure,
// and a narrow single-stage unit (LAT=1, XLEN=16). Inputs are driven and
// outputs sampled around the falling edge.
// ============================================================================
module tb_fu_alu_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // LAT=2, XLEN=32 instance
    logic        en2, ack2, fl2;
    logic [3:0]  op2;
    logic [31:0] a2, b2;
    logic [4:0]  tin2;
    logic        rdy2, fin2, z2, ov2;
    logic [31:0] res2;
    logic [4:0]  tout2;
    logic [39:0] obs2;
    assign obs2 = {fin2, res2, z2, ov2, tout2};

    // LAT=3, XLEN=32 instance
    logic        en3, ack3, fl3;
    logic [3:0]  op3;
    logic [31:0] a3, b3;
    logic [4:0]  tin3;
    logic        rdy3, fin3, z3, ov3;
    logic [31:0] res3;
    logic [4:0]  tout3;
    logic [39:0] obs3;
    assign obs3 = {fin3, res3, z3, ov3, tout3};

    // LAT=1, XLEN=16 instance
    logic        en1, ack1, fl1;
    logic [3:0]  op1;
    logic [15:0] a1, b1;
    logic [4:0]  tin1;
    logic        rdy1, fin1, z1, ov1;
    logic [15:0] res1;
    logic [4:0]  tout1;
    logic [23:0] obs1;
    assign obs1 = {fin1, res1, z1, ov1, tout1};

    fu_alu_pipe #(.XLEN(32), .LAT(2), .TAG_W(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .EN(en2), .ready(rdy2), .ALUControl(op2),
        .ALUA(a2), .ALUB(b2), .tag_in(tin2), .finish(fin2), .ack(ack2),
        .res(res2), .zero(z2), .overflow(ov2), .tag_out(tout2), .flush(fl2)
    );

    fu_alu_pipe #(.XLEN(32), .LAT(3), .TAG_W(5)) dut3 (
        .clk(clk), .rst_n(rst_n), .EN(en3), .ready(rdy3), .ALUControl(op3),
        .ALUA(a3), .ALUB(b3), .tag_in(tin3), .finish(fin3), .ack(ack3),
        .res(res3), .zero(z3), .overflow(ov3), .tag_out(tout3), .flush(fl3)
    );

    fu_alu_pipe #(.XLEN(16), .LAT(1), .TAG_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .EN(en1), .ready(rdy1), .ALUControl(op1),
        .ALUA(a1), .ALUB(b1), .tag_in(tin1), .finish(fin1), .ack(ack1),
        .res(res1), .zero(z1), .overflow(ov1), .tag_out(tout1), .flush(fl1)
    );

    // Reset state of all three instances, observed before any clock edge
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (obs2 !== 40'd0) begin
            errors++;
            $display("[TB] FAIL reset_out2 got %h exp %h", obs2, 40'd0);
        end
        checks++;
        if (obs3 !== 40'd0) begin
            errors++;
            $display("[TB] FAIL reset_out3 got %h exp %h", obs3, 40'd0);
        end
        checks++;
        if (obs1 !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_out1 got %h exp %h", obs1, 24'd0);
        end
        checks++;
        if ({rdy2, rdy3, rdy1} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b exp %b", {rdy2, rdy3, rdy1}, 3'b111);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ADD with signed overflow, latency of exactly two cycles
    task automatic test_add();
        logic [39:0] e;
        @(negedge clk);
        en2 = 1'b1; op2 = 4'h1; a2 = 32'h7FFF_FFFF; b2 = 32'h1; tin2 = 5'd3; ack2 = 1'b1;
        #1;
        checks++;
        if (rdy2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_ready got %b exp 1", rdy2);
        end
        @(negedge clk);
        en2 = 1'b0;
        #1;
        checks++;
        if (fin2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_early got %b exp 0", fin2);
        end
        @(negedge clk);
        #1;
        e = {1'b1, 32'h8000_0000, 1'b0, 1'b1, 5'd3};
        checks++;
        if (obs2 !== e) begin
            errors++;
            $display("[TB] FAIL add_result got %h exp %h", obs2, e);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fin2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_retired got %b exp 0", fin2);
        end
    endtask

    // Four back-to-back ops: SUB, SRA, SLT, SLTU on consecutive cycles
    task automatic test_back_to_back();
        logic [3:0]  ops  [4] = '{4'h2, 4'hA, 4'h8, 4'h9};
        logic [31:0] as   [4] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs   [4] = '{32'd5, 32'd4, 32'd1, 32'd1};
        logic [4:0]  tags [4] = '{5'd1, 5'd2, 5'd4, 5'd5};
        logic [39:0] exps [4] = '{
            {1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd1},
            {1'b1, 32'hF800_0000, 1'b0, 1'b0, 5'd2},
            {1'b1, 32'h0000_0001, 1'b0, 1'b0, 5'd4},
            {1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd5}
        };
        ack2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) begin
                en2 = 1'b1; op2 = ops[i]; a2 = as[i]; b2 = bs[i]; tin2 = tags[i];
            end else begin
                en2 = 1'b0;
            end
            #1;
            if (i >= 2 && i < 6) begin
                checks++;
                if (obs2 !== exps[i-2]) begin
                    errors++;
                    $display("[TB] FAIL b2b_result[%0d] got %h exp %h", i - 2, obs2, exps[i-2]);
                end
            end
            if (i == 6) begin
                checks++;
                if (fin2 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_drain got %b exp 0", fin2);
                end
            end
        end
    endtask

    // LAT=3 with ack held low: three ops fill the pipe, the fourth is dropped
    task automatic test_backpressure();
        logic [3:0]  ops  [4] = '{4'h1, 4'h5, 4'h6, 4'h4};
        logic [31:0] as   [4] = '{32'h10, 32'hFF00, 32'h1, 32'h1};
        logic [31:0] bs   [4] = '{32'h20, 32'h0FF0, 32'd31, 32'h2};
        logic [4:0]  tags [4] = '{5'd1, 5'd2, 5'd3, 5'd7};
        logic [39:0] exps [3] = '{
            {1'b1, 32'h0000_0030, 1'b0, 1'b0, 5'd1},
            {1'b1, 32'h0000_F0F0, 1'b0, 1'b0, 5'd2},
            {1'b1, 32'h8000_0000, 1'b0, 1'b0, 5'd3}
        };
        logic er;
        ack3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en3 = 1'b1; op3 = ops[i]; a3 = as[i]; b3 = bs[i]; tin3 = tags[i];
            #1;
            er = (i < 3);
            checks++;
            if (rdy3 !== er) begin
                errors++;
                $display("[TB] FAIL bp_fill_ready[%0d] got %b exp %b", i, rdy3, er);
            end
            if (i == 3) begin
                checks++;
                if (obs3 !== exps[0]) begin
                    errors++;
                    $display("[TB] FAIL bp_first_out got %h exp %h", obs3, exps[0]);
                end
            end
        end
        @(negedge clk);
        en3 = 1'b0;
        #1;
        checks++;
        if ({rdy3, obs3} !== {1'b0, exps[0]}) begin
            errors++;
            $display("[TB] FAIL bp_hold got %h exp %h", {rdy3, obs3}, {1'b0, exps[0]});
        end
        @(negedge clk);
        ack3 = 1'b1;
        #1;
        checks++;
        if ({rdy3, obs3} !== {1'b1, exps[0]}) begin
            errors++;
            $display("[TB] FAIL bp_ack_ready got %h exp %h", {rdy3, obs3}, {1'b1, exps[0]});
        end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs3 !== exps[i]) begin
                errors++;
                $display("[TB] FAIL bp_retire[%0d] got %h exp %h", i, obs3, exps[i]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (fin3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_dropped got %b exp 0", fin3);
        end
    endtask

    // Flush kills two in-flight ops and blocks the op offered with it
    task automatic test_flush();
        logic [39:0] e;
        ack2 = 1'b1;
        @(negedge clk);
        en2 = 1'b1; op2 = 4'h1; a2 = 32'd1; b2 = 32'd1; tin2 = 5'd1;
        @(negedge clk);
        op2 = 4'h1; a2 = 32'd2; b2 = 32'd2; tin2 = 5'd2;
        @(negedge clk);
        fl2 = 1'b1; op2 = 4'h1; a2 = 32'd3; b2 = 32'd3; tin2 = 5'd3;
        #1;
        checks++;
        if (rdy2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_ready got %b exp 0", rdy2);
        end
        @(negedge clk);
        fl2 = 1'b0; op2 = 4'h2; a2 = 32'd9; b2 = 32'd4; tin2 = 5'd6;
        #1;
        checks++;
        if ({fin2, rdy2} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush_killed got %b exp %b", {fin2, rdy2}, 2'b01);
        end
        @(negedge clk);
        en2 = 1'b0;
        #1;
        checks++;
        if (fin2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_no_accept got %b exp 0", fin2);
        end
        @(negedge clk);
        #1;
        e = {1'b1, 32'd5, 1'b0, 1'b0, 5'd6};
        checks++;
        if (obs2 !== e) begin
            errors++;
            $display("[TB] FAIL flush_after got %h exp %h", obs2, e);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fin2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_after_drain got %b exp 0", fin2);
        end
    endtask

    // Asynchronous reset with two ops in flight
    task automatic test_async_reset();
        logic [39:0] e;
        ack2 = 1'b1;
        @(negedge clk);
        en2 = 1'b1; op2 = 4'h1; a2 = 32'h100; b2 = 32'h1; tin2 = 5'd5;
        @(negedge clk);
        op2 = 4'h1; a2 = 32'd2; b2 = 32'd3; tin2 = 5'd6;
        @(negedge clk);
        en2 = 1'b0;
        #1;
        e = {1'b1, 32'h101, 1'b0, 1'b0, 5'd5};
        checks++;
        if (obs2 !== e) begin
            errors++;
            $display("[TB] FAIL arst_pre got %h exp %h", obs2, e);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy2, obs2} !== {1'b1, 40'd0}) begin
            errors++;
            $display("[TB] FAIL arst_immediate got %h exp %h", {rdy2, obs2}, {1'b1, 40'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (fin2 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL arst_nothing_retires[%0d] got %b exp 0", i, fin2);
            end
        end
    endtask

    // LAT=1, XLEN=16: unknown opcode, Ap4 wrap, ADD overflow with a stall
    task automatic test_lat1_w16();
        logic [23:0] e;
        @(negedge clk);
        en1 = 1'b1; op1 = 4'hF; a1 = 16'h1234; b1 = 16'h5678; tin1 = 5'd2; ack1 = 1'b1;
        @(negedge clk);
        op1 = 4'hB; a1 = 16'hFFFE; b1 = 16'h0; tin1 = 5'd3;
        #1;
        e = {1'b1, 16'h0000, 1'b1, 1'b0, 5'd2};
        checks++;
        if (obs1 !== e) begin
            errors++;
            $display("[TB] FAIL l1_unknown_op got %h exp %h", obs1, e);
        end
        @(negedge clk);
        op1 = 4'h1; a1 = 16'h7FFF; b1 = 16'h0001; tin1 = 5'd4;
        #1;
        e = {1'b1, 16'h0002, 1'b0, 1'b0, 5'd3};
        checks++;
        if (obs1 !== e) begin
            errors++;
            $display("[TB] FAIL l1_ap4 got %h exp %h", obs1, e);
        end
        @(negedge clk);
        en1 = 1'b0; ack1 = 1'b0;
        #1;
        e = {1'b1, 16'h8000, 1'b0, 1'b1, 5'd4};
        checks++;
        if ({rdy1, obs1} !== {1'b0, e}) begin
            errors++;
            $display("[TB] FAIL l1_add_ovf got %h exp %h", {rdy1, obs1}, {1'b0, e});
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs1 !== e) begin
            errors++;
            $display("[TB] FAIL l1_hold got %h exp %h", obs1, e);
        end
        ack1 = 1'b1;
        #1;
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL l1_ack_ready got %b exp 1", rdy1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fin1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL l1_drain got %b exp 0", fin1);
        end
    endtask

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en2 = 1'b0; ack2 = 1'b0; fl2 = 1'b0; op2 = '0; a2 = '0; b2 = '0; tin2 = '0;
        en3 = 1'b0; ack3 = 1'b0; fl3 = 1'b0; op3 = '0; a3 = '0; b3 = '0; tin3 = '0;
        en1 = 1'b0; ack1 = 1'b0; fl1 = 1'b0; op1 = '0; a1 = '0; b1 = '0; tin1 = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_lat1_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_alu_pipe.md
# fu_alu_pipe

Parametrised, pipelined integer ALU functional unit for the dynamically scheduled core. It replaces the single-cycle, non-pipelined ALU FU. The new unit has configurable width and latency, carries a destination tag through the pipeline, and accepts one op per cycle. It uses an elastic valid/ready pipeline with write-back back-pressure and a flush input. It sits between the issue stage (scoreboard/reservation logic) and the common write-back arbiter.

## Interface
Parameters:
- XLEN, 32: operand/result width; power of two, ≥8.
- LAT, 2: issue-to-finish latency in cycles; legal range 1..4.
- TAG_W, 5: destination tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- EN  in  1  issue valid; the op is accepted on a cycle with EN & ready & ~flush.
- ready  out  1  unit can accept an op this cycle; combinational.
- ALUControl  in  4  opcode, using the team's ALU encoding (listed below).
- ALUA, ALUB  in  XLEN  operands.
- tag_in  in  TAG_W  destination tag.
- finish  out  1  result valid at output stage.
- ack  in  1  write-back accepts the result; the result retires on finish & ack.
- res  out  XLEN  result.
- zero  out  1  res == 0.
- overflow  out  1  signed overflow (ADD/SUB only).
- tag_out  out  TAG_W  tag of the result at the output.
- flush  in  1  synchronous kill of all in-flight ops.

## Operation
- Opcodes: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 SLL, 0111 SRL, 1000 SLT, 1001 SLTU, 1010 SRA, 1011 Ap4 (A+4), 1100 Bout (B).
- Any other opcode produces res = 0 and overflow = 0, and the op still completes and retires normally.
- Arithmetic is modulo 2^XLEN.
- Shift amount is ALUB[log2(XLEN)-1:0]. SRA is arithmetic.
- SLT is a signed compare computed as sign(A-B) XOR sub_overflow. SLTU is the borrow of the (XLEN+1)-bit subtraction.
- ADD overflow: operand signs are equal and the result sign differs. SUB overflow: operand signs differ and the result sign differs from A.
- Pipeline structure:
  - There are LAT stages, each with a valid bit, a tag, and a payload.
  - Stage 1 latches the operands, opcode and tag.
  - The result is computed combinationally from the stage-1 registers and is latched into stage 2.
  - Later stages carry the result, overflow and tag forward.
  - With LAT=1, stage 1 is the output stage and res is combinational from the stage-1 registers.
- Advance rule:
  - Stage LAT (the output stage) empties on ack.
  - Stage i advances when stage i+1 is empty or advancing.
  - ready = ~valid[1] | advance[1].
- Results leave in issue order; no reordering.
- EN while ready=0 is ignored: the op is dropped and no state changes. Issue logic must not do this.
- When finish=0: res, overflow and tag_out are forced to 0, and zero=0.
- flush:
  - Clears every valid bit at the next edge.
  - Takes priority over EN and ack in the same cycle, so no op is accepted and none retires.
  - ready=0 during the flush cycle.

## Timing
- Reset (async assert, sync release): all valid bits are 0. finish=0, res=0, zero=0, overflow=0, tag_out=0, ready=1.
- Reset asserted mid-operation discards all ops immediately, without waiting for a clock edge.
- Latency: an op accepted at edge t is presented with finish=1 after edge t+LAT-1, i.e. LAT cycles after the issue cycle, provided there is no stall.
- Throughput: one op per cycle while ack=1.
- Back-pressure:
  - With ack=0 and finish=1, the output holds stable: res, tag_out and overflow do not change.
  - Upstream stages fill. After LAT accepted ops, ready=0.
  - On the first ack=1 cycle, ready returns to 1 in that same cycle.
- Simultaneous ack and EN with a full pipe: the op is accepted in that cycle and there is no bubble.

## Test plan
- LAT=2, ADD 0x7FFFFFFF + 0x00000001, tag 3, ack=1 → finish=1 exactly 2 cycles after issue; res=0x80000000, overflow=1, zero=0, tag_out=3.
- LAT=2, back-to-back SUB 5-5 (tag 1), SRA 0x80000000>>4 (tag 2), SLT 0xFFFFFFFF vs 1 (tag 4), ack=1 → three consecutive finish cycles:
  - res=0 with zero=1;
  - res=0xF8000000;
  - res=1.
  Tags arrive as 1, 2, 4. The same operands with SLTU give res=0.
- LAT=3, ack=0, issue 4 ops → the first 3 are accepted, ready=0, the 4th is dropped and the output holds op 1. Then ack=1 → ops 1 to 3 retire in order on consecutive cycles, and ready=1 from the first ack cycle.
- LAT=2, flush one cycle after issuing 2 ops, with EN=1 in the flush cycle → no finish follows and the flush-cycle op is not accepted. An op issued the next cycle completes normally.
- Reset asserted asynchronously with 2 ops in flight → finish and res go to 0 immediately and ready=1; nothing retires after release.
- LAT=1, XLEN=16, opcode 1111 and Ap4 0xFFFE → the first gives res=0 and overflow=0 the cycle after issue; the second gives res=0x0002.
